i2c_reg_sequencer: RTL and testbench
====================================

Name: i2c_reg_sequencer

Overview:
Transaction-level sequencer that sits above i2c_bit_controller. It accepts one register-access request (write or read of an 8-bit register on a 7-bit slave address) and turns it into the correct START/WR/RESTART/RD/STOP command stream. It paces that stream on the bit controller's ready handshake, checks slave ACKs, and returns read data or an error code. It is the single owner of the bit controller's command port.

Parameters:
TIMEOUT_CYCLES, 4096, max clk_i cycles allowed per bit-controller command (busy phase plus done phase) before abort
TO_W, 13, width of timeout counter; must satisfy 2**TO_W > TIMEOUT_CYCLES

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request present
req_ready_o  out  1  sequencer idle, request accepted when valid&ready
req_rw_i  in  1  0=register write, 1=register read
req_dev_i  in  7  slave address
req_reg_i  in  8  register address
req_wdata_i  in  8  write data (ignored on read)
resp_valid_o  out  1  one-cycle pulse, transaction finished
resp_rdata_o  out  8  read data, valid with resp_valid_o on successful read, else 0
resp_err_o  out  2  0=OK, 1=address NACK, 2=data/register NACK, 3=timeout
bc_cmd_o  out  3  command to bit controller (START=001, WR=010, RD=011, STOP=100, RESTART=101)
bc_din_o  out  8  byte to bit controller
bc_wr_o  out  1  one-cycle command strobe
bc_last_o  out  1  on RD: master NACKs this byte (always 1 here, single-byte reads)
bc_ready_i  in  1  bit controller idle / command complete
bc_ack_i  in  1  slave ACK of last WR byte, 1=ACKed, valid when bc_ready_i rises
bc_dout_i  in  8  byte from last RD, valid when bc_ready_i rises

Behaviour:
- Reset (async, rstn_i=0): state IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, bc_wr_o=0, bc_cmd_o=000, bc_din_o=0, bc_last_o=0, step=0, timeout counter=0. Reset mid-transaction abandons the stream with no STOP issued.
- Request latched (dev, reg, wdata, rw) on the cycle valid&ready; req_ready_o drops on the next cycle and stays 0 until the cycle after resp_valid_o.
- Write step list: START; WR {dev,0}; WR reg; WR wdata; STOP.
- Read step list: START; WR {dev,0}; WR reg; RESTART; WR {dev,1}; RD (bc_last_o=1); STOP.
- FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> EVAL -> (ISSUE with step+1 | RESP) -> IDLE.
- ISSUE: waits for bc_ready_i=1, then drives bc_cmd_o/bc_din_o and pulses bc_wr_o for exactly one cycle. cmd/din are held stable until WAIT_DONE exits.
- WAIT_BUSY: waits for bc_ready_i=0. WAIT_DONE: waits for bc_ready_i=1, then samples bc_ack_i/bc_dout_i.
- Timeout counter clears on ISSUE and counts during WAIT_BUSY and WAIT_DONE. Reaching TIMEOUT_CYCLES sets err=3 and goes to RESP without a STOP.
- EVAL after WR: if bc_ack_i=0, record err=1 when the byte was an address byte, else err=2; jump to the STOP step. Only the first error is kept.
- EVAL after RD: capture bc_dout_i into the rdata register.
- RESP: resp_valid_o=1 for one cycle. resp_rdata_o equals captured data only when rw=1 and err=0, else 0. resp_err_o and resp_rdata_o hold until the next request is accepted.
- req_valid_i asserted while busy is ignored; no queueing.

Decomposition:
- Package i2c_pkg: command constants (START/WR/RD/STOP/RESTART), error code constants, FSM state enum.
- No sub-module. The timeout counter and step ROM stay inline.

Test Plan:
- Write dev=0x50, reg=0x10, data=0xA5, all ACK -> bc strobes carry START, WR 0xA0, WR 0x10, WR 0xA5, STOP in order; resp_err_o=0, resp_rdata_o=0.
- Read dev=0x50, reg=0x22, model returns 0x3C -> START, WR 0xA0, WR 0x22, RESTART, WR 0xA1, RD with bc_last_o=1, STOP; resp_rdata_o=0x3C, resp_err_o=0.
- Write with model NACKing the address byte -> START, WR 0xA0, STOP only; resp_err_o=1.
- Read with NACK on the register byte -> START, WR, WR, STOP; resp_err_o=2, resp_rdata_o=0.
- Model holds bc_ready_i=0 after WR -> resp_valid_o exactly TIMEOUT_CYCLES (±2) cycles after the strobe; resp_err_o=3; no STOP strobe.
- rstn_i low during WAIT_DONE of a read -> all outputs return to reset values immediately; a new write request then completes normally with err=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C register sequencer: bit-controller command codes,
// response error codes, FSM states and the per-step command table.
package i2c_pkg;

  localparam logic [2:0] CMD_NONE    = 3'b000;
  localparam logic [2:0] CMD_START   = 3'b001;
  localparam logic [2:0] CMD_WR      = 3'b010;
  localparam logic [2:0] CMD_RD      = 3'b011;
  localparam logic [2:0] CMD_STOP    = 3'b100;
  localparam logic [2:0] CMD_RESTART = 3'b101;

  localparam logic [1:0] ERR_OK        = 2'd0;
  localparam logic [1:0] ERR_ADDR_NACK = 2'd1;
  localparam logic [1:0] ERR_DATA_NACK = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_EVAL,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    DIN_ZERO,
    DIN_DEV_W,
    DIN_DEV_R,
    DIN_REG,
    DIN_WDATA
  } din_sel_e;

  typedef struct packed {
    logic [2:0] cmd;
    din_sel_e   sel;
  } step_t;

  // Step table: write = START, WR dev/W, WR reg, WR data, STOP;
  // read = START, WR dev/W, WR reg, RESTART, WR dev/R, RD, STOP.
  function automatic step_t step_rom(input logic rw, input logic [2:0] step);
    step_t s;
    s.cmd = CMD_STOP;
    s.sel = DIN_ZERO;
    case (step)
      3'd0: s.cmd = CMD_START;
      3'd1: begin s.cmd = CMD_WR; s.sel = DIN_DEV_W; end
      3'd2: begin s.cmd = CMD_WR; s.sel = DIN_REG; end
      3'd3: begin
        if (rw) s.cmd = CMD_RESTART;
        else begin s.cmd = CMD_WR; s.sel = DIN_WDATA; end
      end
      3'd4: if (rw) begin s.cmd = CMD_WR; s.sel = DIN_DEV_R; end
      3'd5: if (rw) s.cmd = CMD_RD;
      default: s.cmd = CMD_STOP;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] last_step_of(input logic rw);
    return rw ? 3'd6 : 3'd4;
  endfunction

endpackage

// File: rtl/i2c_reg_sequencer.sv
// Turns one register read/write request into a paced START/WR/RESTART/RD/STOP
// command stream for the I2C bit controller, checking ACKs and timing out stalls.
module i2c_reg_sequencer
  import i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rw_i,
  input  logic [6:0] req_dev_i,
  input  logic [7:0] req_reg_i,
  input  logic [7:0] req_wdata_i,
  output logic       resp_valid_o,
  output logic [7:0] resp_rdata_o,
  output logic [1:0] resp_err_o,
  output logic [2:0] bc_cmd_o,
  output logic [7:0] bc_din_o,
  output logic       bc_wr_o,
  output logic       bc_last_o,
  input  logic       bc_ready_i,
  input  logic       bc_ack_i,
  input  logic [7:0] bc_dout_i
);

  state_e          state_reg, state_next;
  logic            rw_reg;
  logic [6:0]      dev_reg;
  logic [7:0]      reg_addr_reg, wdata_reg;
  logic [2:0]      step_reg, step_next;
  logic [1:0]      err_reg, err_next;
  logic [7:0]      rdata_reg, rdata_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            ack_reg, ack_next;
  logic [2:0]      cmd_reg, cmd_next;
  logic [7:0]      din_reg, din_next;
  logic            wr_reg, wr_next;
  logic            last_reg, last_next;
  logic [1:0]      resp_err_reg, resp_err_next;
  logic [7:0]      resp_rdata_reg, resp_rdata_next;

  logic            accept, timed_out, nack_seen, is_addr_byte;
  logic [2:0]      last_step;
  step_t           cur_step;
  logic [7:0]      cur_din;

  assign accept       = (state_reg == S_IDLE) && req_valid_i;
  assign timed_out    = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
  assign nack_seen    = (cmd_reg == CMD_WR) && !ack_reg;
  assign last_step    = last_step_of(rw_reg);
  assign is_addr_byte = (step_reg == 3'd1) || (rw_reg && step_reg == 3'd4);
  assign cur_step     = step_rom(rw_reg, step_reg);

  always_comb begin
    case (cur_step.sel)
      DIN_DEV_W: cur_din = {dev_reg, 1'b0};
      DIN_DEV_R: cur_din = {dev_reg, 1'b1};
      DIN_REG:   cur_din = reg_addr_reg;
      DIN_WDATA: cur_din = wdata_reg;
      default:   cur_din = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (req_valid_i) state_next = S_ISSUE;
      S_ISSUE:     if (bc_ready_i) state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!bc_ready_i)    state_next = S_WAIT_DONE;
        else if (timed_out) state_next = S_RESP;
      end
      S_WAIT_DONE: begin
        if (bc_ready_i)     state_next = S_EVAL;
        else if (timed_out) state_next = S_RESP;
      end
      S_EVAL:      state_next = (nack_seen || step_reg != last_step) ? S_ISSUE : S_RESP;
      S_RESP:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    step_next       = step_reg;
    err_next        = err_reg;
    rdata_next      = rdata_reg;
    to_cnt_next     = to_cnt_reg;
    ack_next        = ack_reg;
    cmd_next        = cmd_reg;
    din_next        = din_reg;
    wr_next         = 1'b0;
    last_next       = last_reg;
    resp_err_next   = resp_err_reg;
    resp_rdata_next = resp_rdata_reg;
    case (state_reg)
      S_IDLE: if (req_valid_i) begin
        step_next       = 3'd0;
        err_next        = ERR_OK;
        rdata_next      = 8'h00;
        resp_err_next   = ERR_OK;
        resp_rdata_next = 8'h00;
      end
      S_ISSUE: begin
        to_cnt_next = '0;
        if (bc_ready_i) begin
          cmd_next  = cur_step.cmd;
          din_next  = cur_din;
          last_next = (cur_step.cmd == CMD_RD);
          wr_next   = 1'b1;
        end
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        to_cnt_next = to_cnt_reg + 1'b1;
        if (state_reg == S_WAIT_DONE && bc_ready_i) begin
          ack_next = bc_ack_i;
          if (cmd_reg == CMD_RD) rdata_next = bc_dout_i;
        end else if (state_next == S_RESP && err_reg == ERR_OK) begin
          err_next = ERR_TIMEOUT;
        end
      end
      S_EVAL: begin
        if (nack_seen) begin
          if (err_reg == ERR_OK) err_next = is_addr_byte ? ERR_ADDR_NACK : ERR_DATA_NACK;
          step_next = last_step;
        end else if (step_reg != last_step) begin
          step_next = step_reg + 3'd1;
        end
      end
      default: ;
    endcase
    // Response fields are frozen on entry to RESP and held until the next accept.
    if (state_next == S_RESP && state_reg != S_RESP) begin
      resp_err_next   = err_next;
      resp_rdata_next = (rw_reg && err_next == ERR_OK) ? rdata_next : 8'h00;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rw_reg         <= 1'b0;
      dev_reg        <= 7'h00;
      reg_addr_reg   <= 8'h00;
      wdata_reg      <= 8'h00;
      step_reg       <= 3'd0;
      err_reg        <= ERR_OK;
      rdata_reg      <= 8'h00;
      to_cnt_reg     <= '0;
      ack_reg        <= 1'b0;
      cmd_reg        <= CMD_NONE;
      din_reg        <= 8'h00;
      wr_reg         <= 1'b0;
      last_reg       <= 1'b0;
      resp_err_reg   <= ERR_OK;
      resp_rdata_reg <= 8'h00;
    end else begin
      if (accept) begin
        rw_reg       <= req_rw_i;
        dev_reg      <= req_dev_i;
        reg_addr_reg <= req_reg_i;
        wdata_reg    <= req_wdata_i;
      end
      step_reg       <= step_next;
      err_reg        <= err_next;
      rdata_reg      <= rdata_next;
      to_cnt_reg     <= to_cnt_next;
      ack_reg        <= ack_next;
      cmd_reg        <= cmd_next;
      din_reg        <= din_next;
      wr_reg         <= wr_next;
      last_reg       <= last_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
    end
  end

  assign req_ready_o  = (state_reg == S_IDLE);
  assign resp_valid_o = (state_reg == S_RESP);
  assign resp_err_o   = resp_err_reg;
  assign resp_rdata_o = resp_rdata_reg;
  assign bc_cmd_o     = cmd_reg;
  assign bc_din_o     = din_reg;
  assign bc_wr_o      = wr_reg;
  assign bc_last_o    = last_reg;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench: a bit-controller model answers commands, expected command
// streams and responses are queued at issue time and checked by a monitor.
module tb_i2c_reg_sequencer;

  localparam int T  = 64;
  localparam int TW = 7;
  localparam logic [2:0] C_START = 3'b001, C_WR = 3'b010, C_RD = 3'b011,
                         C_STOP = 3'b100, C_RESTART = 3'b101;

  typedef struct { logic [2:0] cmd; logic [7:0] din; } cmd_t;
  typedef struct { logic [1:0] err; logic [7:0] rdata; } resp_t;

  logic       clk = 1'b0, rstn = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_rw = 1'b0;
  logic [6:0] req_dev = 7'h00;
  logic [7:0] req_reg = 8'h00, req_wdata = 8'h00;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic [1:0] resp_err;
  logic [2:0] bc_cmd;
  logic [7:0] bc_din;
  logic       bc_wr, bc_last;
  logic       bc_ready = 1'b1, bc_ack = 1'b0;
  logic [7:0] bc_dout = 8'h00;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(T), .TO_W(TW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
    .req_dev_i(req_dev), .req_reg_i(req_reg), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .bc_cmd_o(bc_cmd), .bc_din_o(bc_din), .bc_wr_o(bc_wr), .bc_last_o(bc_last),
    .bc_ready_i(bc_ready), .bc_ack_i(bc_ack), .bc_dout_i(bc_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cmd_t  exp_cmd_q[$];
  resp_t exp_resp_q[$];
  int    checks = 0, failures = 0;
  int    resp_cnt = 0, last_strobe_cyc = 0;
  logic [1:0] last_err = 2'd0;
  logic [7:0] last_rdata = 8'h00;

  int         m_nack = -1, m_hang = -1, m_cmd_idx = 0, m_wr_idx = 0, m_busy = 0;
  bit         m_hanging = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic [2:0] c, input logic [7:0] d);
    cmd_t r;
    r.cmd = c;
    r.din = d;
    return r;
  endfunction

  // Bit-controller model: accepts a strobe, goes busy, then reports ACK/data.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        bc_ready = 1'b1; m_hanging = 1'b0; m_busy = 0;
      end else if (m_hanging) begin
        if (resp_valid) begin m_hanging = 1'b0; bc_ready = 1'b1; end
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) bc_ready = 1'b1;
      end else if (bc_wr) begin
        bc_ready = 1'b0;
        if (m_cmd_idx == m_hang) m_hanging = 1'b1;
        else begin
          if (bc_cmd == C_WR) begin bc_ack = (m_wr_idx != m_nack); m_wr_idx++; end
          if (bc_cmd == C_RD) bc_dout = m_rdata;
          m_busy = $urandom_range(1, 4);
        end
        m_cmd_idx++;
      end
    end
  end

  // Monitor: compares every strobe and every response with the queued expectations.
  initial begin
    cmd_t  ec;
    resp_t er;
    int    diff;
    forever begin
      @(negedge clk);
      if (rstn && bc_wr) begin
        last_strobe_cyc = cyc;
        if (exp_cmd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_strobe: got cmd %0h expected no command", bc_cmd);
        end else begin
          ec = exp_cmd_q.pop_front();
          check("bc_cmd", 32'(bc_cmd), 32'(ec.cmd));
          if (ec.cmd == C_WR) check("bc_din", 32'(bc_din), 32'(ec.din));
          if (ec.cmd == C_RD) check("bc_last", 32'(bc_last), 32'd1);
        end
      end
      if (rstn && resp_valid) begin
        if (exp_resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp: got err %0d expected no response", resp_err);
        end else begin
          er = exp_resp_q.pop_front();
          check("resp_err", 32'(resp_err), 32'(er.err));
          check("resp_rdata", 32'(resp_rdata), 32'(er.rdata));
          check("cmds_outstanding", 32'(exp_cmd_q.size()), 32'd0);
          if (er.err == 2'd3) begin
            diff = cyc - last_strobe_cyc;
            check("timeout_latency_ok", 32'(diff >= T - 2 && diff <= T + 2), 32'd1);
          end
          last_err   = er.err;
          last_rdata = er.rdata;
          $display("txn %0d: err=%0d rdata=%02h (cycle %0d)", resp_cnt, resp_err, resp_rdata, cyc);
        end
        resp_cnt++;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_bc_wr", 32'(bc_wr), 32'd0);
    check("rst_bc_cmd", 32'(bc_cmd), 32'd0);
    check("rst_bc_din", 32'(bc_din), 32'd0);
    check("rst_bc_last", 32'(bc_last), 32'd0);
  endtask

  // Push the spec-derived command list and response, then configure the model.
  task automatic expect_txn(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [7:0] wd, input logic [7:0] rd,
                            input int nack, input int hang);
    cmd_t  full[$];
    bit    is_addr[$];
    resp_t r;
    int    wr_k;
    full.push_back(mk(C_START, 8'h00));   is_addr.push_back(1'b0);
    full.push_back(mk(C_WR, {dev, 1'b0})); is_addr.push_back(1'b1);
    full.push_back(mk(C_WR, rg));          is_addr.push_back(1'b0);
    if (!rw) begin
      full.push_back(mk(C_WR, wd));        is_addr.push_back(1'b0);
    end else begin
      full.push_back(mk(C_RESTART, 8'h00)); is_addr.push_back(1'b0);
      full.push_back(mk(C_WR, {dev, 1'b1})); is_addr.push_back(1'b1);
      full.push_back(mk(C_RD, 8'h00));      is_addr.push_back(1'b0);
    end
    full.push_back(mk(C_STOP, 8'h00));     is_addr.push_back(1'b0);
    r.err = 2'd0;
    wr_k  = 0;
    for (int i = 0; i < full.size(); i++) begin
      exp_cmd_q.push_back(full[i]);
      if (i == hang) begin r.err = 2'd3; break; end
      if (full[i].cmd == C_WR) begin
        if (wr_k == nack) begin
          r.err = is_addr[i] ? 2'd1 : 2'd2;
          exp_cmd_q.push_back(mk(C_STOP, 8'h00));
          break;
        end
        wr_k++;
      end
    end
    r.rdata = (rw && r.err == 2'd0) ? rd : 8'h00;
    exp_resp_q.push_back(r);
    m_nack = nack; m_hang = hang; m_rdata = rd; m_cmd_idx = 0; m_wr_idx = 0;
  endtask

  task automatic send_req(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("req_ready_drop", 32'(req_ready), 32'd0);
  endtask

  task automatic run_txn(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] rd,
                         input int nack, input int hang);
    int start;
    expect_txn(rw, dev, rg, wd, rd, nack, hang);
    start = resp_cnt;
    send_req(rw, dev, rg, wd);
    // A request presented while busy must be ignored.
    req_rw = $urandom_range(0, 1); req_dev = 7'($urandom); req_reg = 8'($urandom);
    req_wdata = 8'($urandom);
    repeat (2) @(negedge clk);
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3000 && resp_cnt == start; i++) @(negedge clk);
    if (resp_cnt == start) begin
      checks++; failures++;
      $display("FAIL resp_wait: got no response expected one within 3000 cycles");
    end else begin
      @(posedge clk); #1;
      check("req_ready_back", 32'(req_ready), 32'd1);
      check("resp_err_hold", 32'(resp_err), 32'(last_err));
      check("resp_rdata_hold", 32'(resp_rdata), 32'(last_rdata));
    end
  endtask

  initial begin
    int   r, nack, hang;
    bit   rw;
    #2 rstn = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1);
    run_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, -1, -1);
    run_txn(1'b0, 7'h50, 8'h10, 8'h5A, 8'h00, 0, -1);
    run_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h77, 1, -1);
    run_txn(1'b0, 7'h51, 8'h33, 8'h44, 8'h00, -1, 1);

    // Abort a read while it waits on the register byte.
    expect_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h99, -1, 2);
    send_req(1'b1, 7'h50, 8'h22, 8'h00);
    for (int i = 0; i < 500 && m_cmd_idx < 3; i++) @(negedge clk);
    check("abort_reached_reg_byte", 32'(m_cmd_idx), 32'd3);
    repeat (4) @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_outputs();
    exp_cmd_q.delete();
    exp_resp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_txn(1'b0, 7'h2A, 8'h01, 8'hC3, 8'h00, -1, -1);

    for (int n = 0; n < 40; n++) begin
      rw   = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 9);
      nack = (r < 6) ? -1 : r - 6;
      hang = -1;
      if ($urandom_range(0, 9) == 0) begin
        r    = $urandom_range(1, 3);
        hang = (rw && r == 3) ? 4 : r;
        nack = -1;
      end
      run_txn(rw, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), nack, hang);
    end

    repeat (5) @(negedge clk);
    check("leftover_resp", 32'(exp_resp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish expected finish before 90000 cycles");
    $fatal(1, "global timeout");
  end

endmodule
